pe_sequencer: RTL and testbench
===============================

Name: pe_sequencer

Overview:
Driver for the `pe` multiply-accumulate element. It holds an activation vector and a weight vector in a small local buffer. On a job request it clears the PE, streams N operand pairs one per cycle, captures the accumulated dot product, and returns it on a valid/ready result port. It is the feeding/draining end of the PE operand interface (pe_reset / activation / weight in, output back).

Parameters:
BW, 8, operand width; PE result width is 2*BW.
DEPTH, 16, maximum vector length (buffer entries).
AW, $clog2(DEPTH), buffer address width.

Ports:
i_clock  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_wr_en  in  1  buffer write strobe
i_wr_addr  in  AW  buffer write address
i_wr_act  in  BW  activation to store
i_wr_weight  in  BW  weight to store
i_start_valid  in  1  job request
o_start_ready  out  1  job accepted when valid&&ready
i_len  in  AW+1  job vector length, legal range 1..DEPTH
o_pe_reset  out  1  drives PE i_reset
o_activation  out  BW  drives PE i_activation
o_weight  out  BW  drives PE i_weight
i_pe_output  in  2*BW  PE o_output
o_result_valid  out  1  result available
i_result_ready  in  1  result consumed when valid&&ready
o_result  out  2*BW  captured dot product
o_busy  out  1  high in any state except IDLE
o_error  out  1  one-cycle pulse on an illegal-length request

Behaviour:
- One clock. Reset is synchronous and active-high; clock and reset ports are named i_clock and i_reset.
- Reset values:
  - State goes to IDLE.
  - o_pe_reset=1 while i_reset is high, so the PE is cleared alongside this block.
  - o_activation=0, o_weight=0, o_result=0, o_result_valid=0, o_busy=0, o_error=0.
  - o_start_ready goes to 1 in the first cycle after reset deasserts.
- Buffer contents are not reset. A bench must write them before use.
- All PE-facing outputs and o_result/o_result_valid are registered.
- PE contract: on each rising edge, acc <= reset ? 0 : acc + act*weight, modulo 2^(2*BW). i_pe_output shows acc.
- States:
  - IDLE:
    - o_start_ready=1; PE operands held at 0.
    - Accept with legal i_len: latch len, idx=0, go to CLEAR.
    - Accept with i_len==0 or i_len>DEPTH: o_error pulses for 1 cycle, stay IDLE, PE untouched.
  - CLEAR: o_pe_reset=1 for exactly one cycle, operands 0, then STREAM.
  - STREAM:
    - For len consecutive cycles, o_activation/o_weight = buffer[idx], with idx = 0..len-1 and o_pe_reset=0.
    - Go to CAPTURE after idx==len-1.
  - CAPTURE:
    - Operands forced to 0 (zero-product padding).
    - o_result <= i_pe_output, which now equals the full sum; o_result_valid <= 1; go to HOLD.
  - HOLD:
    - o_result and o_result_valid are held stable until i_result_ready.
    - On the handshake cycle: valid drops next cycle, go to IDLE.
- Latency: start accept edge -> o_result_valid high after len+2 edges, if ready was already high.
- Throughput: with ready tied high, a new job can be accepted on the cycle after the handshake.
- Writes:
  - Honoured only while o_busy=0; dropped silently otherwise.
  - A write in the same cycle as an accepted start is honoured and is visible to that job.
- Arithmetic:
  - No saturation; the result wraps modulo 2^(2*BW), as the PE does.
  - The sequencer adds nothing itself.
- Reset mid-operation (any state): return to IDLE next cycle, any pending result discarded, o_pe_reset high during reset.

Decomposition:
- Shared package `pe_pkg`:
  - BW default
  - result width localparam (2*BW)
  - state enum {IDLE, CLEAR, STREAM, CAPTURE, HOLD}
  - length-legality helper function
- One sub-module, `pe_operand_buf`: a DEPTH x (2*BW) register file with one synchronous write port and one combinational read port indexed by idx. The output register sits in pe_sequencer.
- The bench instantiates pe_sequencer together with a real `pe` (BW=8) for end-to-end checks.

Test Plan:
- Basic dot product:
  - Stimulus: write act {1,2,3}, weights {4,5,6}; start len=3, ready high.
  - Response: o_pe_reset high 1 cycle, pairs (1,4),(2,5),(3,6) on consecutive cycles, o_result=32 valid at len+2 edges.
- Constant activation:
  - Stimulus: act {128,128,128}, weights {1,2,3}, len=3.
  - Response: o_result=768.
- Wrap-around:
  - Stimulus: len=4, all act=weight=255.
  - Response: o_result=63492 (260100 mod 65536).
- Backpressure:
  - Stimulus: i_result_ready low for 5 cycles after valid.
  - Response: o_result stable, o_start_ready=0, o_busy=1, a start request is ignored; ready high -> IDLE next cycle.
- Illegal lengths:
  - Stimulus: start with len=0, then len=17.
  - Response: o_error 1-cycle pulse each, o_pe_reset never asserted, state stays IDLE.
- Reset mid-stream and dropped write:
  - Stimulus: assert i_reset at idx=1 of a len=4 job.
  - Response: o_pe_reset=1 and operands 0 during reset, IDLE after; a following len=2 job returns the correct sum.
  - A write issued during STREAM does not change buffer contents.

Source files
------------

// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared widths, state encoding and length check for the PE sequencer
package pe_pkg;

  localparam int PE_BW = 8;
  localparam int PE_RW = 2 * PE_BW;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    CAPTURE,
    HOLD
  } seq_state_e;

  function automatic logic len_legal(input int len, input int depth);
    return (len >= 1) && (len <= depth);
  endfunction

endpackage

// File: rtl/pe.sv
// rtl/pe.sv - multiply-accumulate element; accumulator wraps at 2*BW bits
module pe #(
  parameter int BW = 8
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic [BW-1:0]   i_activation,
  input  logic [BW-1:0]   i_weight,
  output logic [2*BW-1:0] o_output
);

  localparam int RW = 2 * BW;

  logic [RW-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q + RW'(i_activation) * RW'(i_weight);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) acc_q <= '0;
    else         acc_q <= acc_d;
  end

  assign o_output = acc_q;

endmodule

// File: rtl/pe_operand_buf.sv
// rtl/pe_operand_buf.sv - operand register file, one sync write port, one async read port
module pe_operand_buf #(
  parameter int W     = 16,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clock,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [W-1:0]  i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [W-1:0]  o_rd_data
);

  // Contents are deliberately left unreset; users write before reading.
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clock) begin
    if (i_wr_en) mem_q[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = mem_q[i_rd_addr];

endmodule

// File: rtl/pe_sequencer.sv
// rtl/pe_sequencer.sv - feeds buffered operand pairs into a PE and returns the dot product
module pe_sequencer
  import pe_pkg::*;
#(
  parameter int BW    = PE_BW,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_wr_en,
  input  logic [AW-1:0]   i_wr_addr,
  input  logic [BW-1:0]   i_wr_act,
  input  logic [BW-1:0]   i_wr_weight,
  input  logic            i_start_valid,
  output logic            o_start_ready,
  input  logic [AW:0]     i_len,
  output logic            o_pe_reset,
  output logic [BW-1:0]   o_activation,
  output logic [BW-1:0]   o_weight,
  input  logic [2*BW-1:0] i_pe_output,
  output logic            o_result_valid,
  input  logic            i_result_ready,
  output logic [2*BW-1:0] o_result,
  output logic            o_busy,
  output logic            o_error
);

  localparam int RW = 2 * BW;

  seq_state_e    state_q, state_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   idx_q, idx_d;
  logic          pe_reset_q, pe_reset_d;
  logic [BW-1:0] act_q, act_d;
  logic [BW-1:0] wt_q, wt_d;
  logic [RW-1:0] result_q, result_d;
  logic          valid_q, valid_d;
  logic          start_ready_q, start_ready_d;
  logic          busy_q, busy_d;
  logic          error_q, error_d;
  logic [RW-1:0] rd_data;

  pe_operand_buf #(.W(RW), .DEPTH(DEPTH), .AW(AW)) u_buf (
    .i_clock   (i_clock),
    .i_wr_en   (i_wr_en && !busy_q),
    .i_wr_addr (i_wr_addr),
    .i_wr_data ({i_wr_act, i_wr_weight}),
    .i_rd_addr (idx_q[AW-1:0]),
    .o_rd_data (rd_data)
  );

  // idx_q is the entry to present next; it runs one ahead of the pair on the PE port.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    pe_reset_d = 1'b0;
    act_d      = '0;
    wt_d       = '0;
    result_d   = result_q;
    valid_d    = valid_q;
    error_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start_valid && start_ready_q) begin
          if (len_legal(32'(i_len), DEPTH)) begin
            state_d    = CLEAR;
            len_d      = i_len;
            idx_d      = '0;
            pe_reset_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        state_d = STREAM;
        act_d   = rd_data[RW-1:BW];
        wt_d    = rd_data[BW-1:0];
        idx_d   = idx_q + 1'b1;
      end
      STREAM: begin
        if (idx_q == len_q) begin
          state_d = CAPTURE;
        end else begin
          act_d = rd_data[RW-1:BW];
          wt_d  = rd_data[BW-1:0];
          idx_d = idx_q + 1'b1;
        end
      end
      CAPTURE: begin
        result_d = i_pe_output;
        valid_d  = 1'b1;
        state_d  = HOLD;
      end
      HOLD: begin
        if (i_result_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d        = (state_d != IDLE);
    start_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q       <= IDLE;
      len_q         <= '0;
      idx_q         <= '0;
      pe_reset_q    <= 1'b1;
      act_q         <= '0;
      wt_q          <= '0;
      result_q      <= '0;
      valid_q       <= 1'b0;
      start_ready_q <= 1'b1;
      busy_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      pe_reset_q    <= pe_reset_d;
      act_q         <= act_d;
      wt_q          <= wt_d;
      result_q      <= result_d;
      valid_q       <= valid_d;
      start_ready_q <= start_ready_d;
      busy_q        <= busy_d;
      error_q       <= error_d;
    end
  end

  assign o_start_ready  = start_ready_q;
  assign o_pe_reset     = pe_reset_q;
  assign o_activation   = act_q;
  assign o_weight       = wt_q;
  assign o_result       = result_q;
  assign o_result_valid = valid_q;
  assign o_busy         = busy_q;
  assign o_error        = error_q;

endmodule

// File: tb/tb_pe_sequencer.sv
// tb/tb_pe_sequencer.sv - end-to-end bench: pe_sequencer driving a real pe, scoreboarded results
module tb_pe_sequencer;
  import pe_pkg::*;

  localparam int BW = PE_BW;
  localparam int RW = PE_RW;
  localparam int DEPTH = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst;
  logic wr_en;
  logic [AW-1:0] wr_addr;
  logic [BW-1:0] wr_act, wr_wt;
  logic start_valid, start_ready;
  logic [AW:0] len;
  logic pe_reset;
  logic [BW-1:0] act, wt;
  logic [RW-1:0] pe_out;
  logic res_valid, res_ready;
  logic [RW-1:0] result;
  logic busy, error;

  int n_vec = 0;
  int n_bad = 0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] e;
  logic [BW-1:0] act_m[DEPTH];
  logic [BW-1:0] wt_m[DEPTH];
  logic ok;

  always #5 clk = ~clk;

  pe_sequencer #(.BW(BW), .DEPTH(DEPTH), .AW(AW)) dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_wr_en        (wr_en),
    .i_wr_addr      (wr_addr),
    .i_wr_act       (wr_act),
    .i_wr_weight    (wr_wt),
    .i_start_valid  (start_valid),
    .o_start_ready  (start_ready),
    .i_len          (len),
    .o_pe_reset     (pe_reset),
    .o_activation   (act),
    .o_weight       (wt),
    .i_pe_output    (pe_out),
    .o_result_valid (res_valid),
    .i_result_ready (res_ready),
    .o_result       (result),
    .o_busy         (busy),
    .o_error        (error)
  );

  pe #(.BW(BW)) u_pe (
    .i_clock      (clk),
    .i_reset      (pe_reset),
    .i_activation (act),
    .i_weight     (wt),
    .o_output     (pe_out)
  );

  always @(negedge clk) begin
    if (res_valid && res_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL result_unexpected: got %0d, no result expected", result);
      end else begin
        e = exp_q.pop_front();
        if (result !== e) begin
          n_bad++;
          $display("FAIL result: got %0d expected %0d", result, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [BW-1:0] x, input logic [BW-1:0] w);
    wr_en = 1'b1; wr_addr = a; wr_act = x; wr_wt = w;
    act_m[a] = x; wt_m[a] = w;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic start(input logic [AW:0] l);
    start_valid = 1'b1; len = l;
    tick();
    start_valid = 1'b0;
  endtask

  // Entered just after the accept edge; leaves with o_result_valid expected high.
  task automatic check_stream(input int n, input string tag);
    chk({tag, "_clear_rst"}, 32'(pe_reset), 32'd1);
    chk({tag, "_clear_act"}, 32'(act), 32'd0);
    for (int k = 0; k < n; k++) begin
      tick();
      chk({tag, "_act"}, 32'(act), 32'(act_m[k]));
      chk({tag, "_wt"}, 32'(wt), 32'(wt_m[k]));
      chk({tag, "_rst_low"}, 32'(pe_reset), 32'd0);
    end
    tick();
    chk({tag, "_pad_act"}, 32'(act), 32'd0);
    chk({tag, "_early_valid"}, 32'(res_valid), 32'd0);
    tick();
    chk({tag, "_latency_valid"}, 32'(res_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_act = '0; wr_wt = '0;
    start_valid = 1'b0; len = '0; res_ready = 1'b1;
    repeat (3) tick();
    chk("rst_pe_reset", 32'(pe_reset), 32'd1);
    chk("rst_act", 32'(act), 32'd0);
    chk("rst_wt", 32'(wt), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", 32'(start_ready), 32'd1);
    chk("post_rst_pe_reset", 32'(pe_reset), 32'd0);

    // basic dot product; entry 2 written in the same cycle as the start
    wr(4'd0, 8'd1, 8'd4);
    wr(4'd1, 8'd2, 8'd5);
    exp_q.push_back(16'd32);
    wr_en = 1'b1; wr_addr = 4'd2; wr_act = 8'd3; wr_wt = 8'd6;
    act_m[2] = 8'd3; wt_m[2] = 8'd6;
    start(5'd3);
    wr_en = 1'b0;
    check_stream(3, "basic");
    tick();
    chk("basic_valid_drop", 32'(res_valid), 32'd0);
    chk("basic_idle_ready", 32'(start_ready), 32'd1);

    // constant activation
    wr(4'd0, 8'd128, 8'd1);
    wr(4'd1, 8'd128, 8'd2);
    wr(4'd2, 8'd128, 8'd3);
    exp_q.push_back(16'd768);
    start(5'd3);
    check_stream(3, "const");
    tick();

    // wrap-around, then back-to-back job right after the handshake
    for (int k = 0; k < 4; k++) wr(4'(k), 8'd255, 8'd255);
    exp_q.push_back(16'd63492);
    start(5'd4);
    check_stream(4, "wrap");
    exp_q.push_back(16'd63492);
    start_valid = 1'b1; len = 5'd4;
    tick();
    chk("thru_ready", 32'(start_ready), 32'd1);
    tick();
    start_valid = 1'b0;
    check_stream(4, "thru");
    tick();

    // backpressure
    res_ready = 1'b0;
    wr(4'd0, 8'd2, 8'd7);
    wr(4'd1, 8'd3, 8'd11);
    exp_q.push_back(16'd47);
    start(5'd2);
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      tick();
      if (res_valid) ok = 1'b1;
    end
    chk("bp_valid_seen", 32'(ok), 32'd1);
    start_valid = 1'b1; len = 5'd2;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_result", 32'(result), 32'd47);
      chk("bp_valid", 32'(res_valid), 32'd1);
      chk("bp_start_ready", 32'(start_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      chk("bp_pe_reset", 32'(pe_reset), 32'd0);
    end
    start_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    chk("bp_valid_drop", 32'(res_valid), 32'd0);
    chk("bp_idle_busy", 32'(busy), 32'd0);
    chk("bp_idle_ready", 32'(start_ready), 32'd1);
    chk("bp_drained", 32'(exp_q.size()), 32'd0);

    // illegal lengths
    start(5'd0);
    chk("len0_error", 32'(error), 32'd1);
    chk("len0_pe_reset", 32'(pe_reset), 32'd0);
    chk("len0_busy", 32'(busy), 32'd0);
    tick();
    chk("len0_error_pulse", 32'(error), 32'd0);
    chk("len0_pe_reset2", 32'(pe_reset), 32'd0);
    start(5'd17);
    chk("len17_error", 32'(error), 32'd1);
    chk("len17_pe_reset", 32'(pe_reset), 32'd0);
    chk("len17_busy", 32'(busy), 32'd0);
    tick();
    chk("len17_error_pulse", 32'(error), 32'd0);
    chk("len17_ready", 32'(start_ready), 32'd1);

    // reset mid-stream
    wr(4'd0, 8'd10, 8'd1);
    wr(4'd1, 8'd20, 8'd1);
    wr(4'd2, 8'd30, 8'd1);
    wr(4'd3, 8'd40, 8'd1);
    start(5'd4);
    tick();
    tick();
    chk("mid_act_idx1", 32'(act), 32'd20);
    rst = 1'b1;
    tick();
    chk("mid_rst_pe_reset", 32'(pe_reset), 32'd1);
    chk("mid_rst_act", 32'(act), 32'd0);
    chk("mid_rst_wt", 32'(wt), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(res_valid), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("mid_idle_ready", 32'(start_ready), 32'd1);
    chk("mid_idle_busy", 32'(busy), 32'd0);

    // write while busy is dropped: entry 1 must still read back as (20,1)
    exp_q.push_back(16'd30);
    start(5'd2);
    wr_en = 1'b1; wr_addr = 4'd1; wr_act = 8'd99; wr_wt = 8'd99;
    tick();
    wr_en = 1'b0;
    chk("drop_act0", 32'(act), 32'd10);
    tick();
    chk("drop_act1", 32'(act), 32'd20);
    chk("drop_wt1", 32'(wt), 32'd1);
    tick();
    tick();
    chk("drop_valid", 32'(res_valid), 32'd1);
    tick();
    exp_q.push_back(16'd30);
    start(5'd2);
    check_stream(2, "after_drop");
    tick();

    chk("all_results_seen", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
